// File: rtl/mul_issuer.sv
// mul_issuer: execute-stage requester for the Booth multiplier. Issues one RV64M multiply
// at a time, picks the product half the op asks for and holds it until the pipeline takes it.
module mul_issuer #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 63
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_func,
  input  logic            op_word,
  input  logic [XLEN-1:0] op_src1,
  input  logic [XLEN-1:0] op_src2,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic            timeout_err,
  output logic            mul_in_valid,
  output logic            mul_flush,
  output logic            mul_mulw,
  output logic [1:0]      mul_signed,
  output logic [XLEN-1:0] mul_multiplicand,
  output logic [XLEN-1:0] mul_multiplier,
  input  logic            mul_out_ready,
  input  logic            mul_out_valid,
  input  logic [XLEN-1:0] mul_result_hi,
  input  logic [XLEN-1:0] mul_result_lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  // Last wait count before the watchdog fires, so WAIT lasts exactly TIMEOUT cycles.
  localparam logic [5:0] LAST_WAIT = 6'(TIMEOUT - 1);

  state_t          state;
  state_t          state_next;
  logic [5:0]      wait_cnt;
  logic [5:0]      wait_cnt_next;
  logic            accept;
  logic            issue_next;
  logic            flush_next;
  logic            capture;
  logic            timeout_hit;
  logic            in_valid_q;
  logic            sel_hi;
  logic [1:0]      signed_sel;
  logic [XLEN-1:0] src1_sel;
  logic [XLEN-1:0] src2_sel;
  logic [XLEN-1:0] result_sel;

  assign op_ready  = (state == S_IDLE) && mul_out_ready && !flush;
  assign accept    = op_valid && op_ready;
  assign res_valid = (state == S_HOLD);

  // A flush in the issue cycle has to stop the multiplier from ever starting the op.
  assign mul_in_valid = in_valid_q && !flush;

  always_comb begin
    signed_sel = 2'b11;
    if (!op_word) begin
      case (op_func)
        3'b010:  signed_sel = 2'b10;
        3'b011:  signed_sel = 2'b00;
        default: signed_sel = 2'b11;
      endcase
    end
  end

  assign src1_sel = op_word ? {{(XLEN-32){op_src1[31]}}, op_src1[31:0]} : op_src1;
  assign src2_sel = op_word ? {{(XLEN-32){op_src2[31]}}, op_src2[31:0]} : op_src2;

  assign result_sel = mul_mulw ? {{(XLEN-32){mul_result_lo[31]}}, mul_result_lo[31:0]}
                    : sel_hi   ? mul_result_hi
                    :            mul_result_lo;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 6'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    issue_next    = 1'b0;
    flush_next    = 1'b0;
    capture       = 1'b0;
    timeout_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_ISSUE;
          issue_next = 1'b1;
        end
      end
      S_ISSUE: begin
        wait_cnt_next = 6'd0;
        state_next    = flush ? S_IDLE : S_WAIT;
      end
      // Flush beats a same-cycle result; the multiplier is told to abandon its work.
      S_WAIT: begin
        if (flush) begin
          flush_next = 1'b1;
          state_next = S_DRAIN;
        end else if (mul_out_valid) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end else if (wait_cnt == LAST_WAIT) begin
          timeout_hit = 1'b1;
          flush_next  = 1'b1;
          state_next  = S_DRAIN;
        end else begin
          wait_cnt_next = wait_cnt + 6'd1;
        end
      end
      S_HOLD: begin
        if (flush || res_ready) state_next = S_IDLE;
      end
      S_DRAIN: begin
        if (mul_out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_valid_q       <= 1'b0;
      mul_flush        <= 1'b0;
      mul_mulw         <= 1'b0;
      mul_signed       <= 2'b00;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      sel_hi           <= 1'b0;
      res_data         <= '0;
      timeout_err      <= 1'b0;
    end else begin
      in_valid_q <= issue_next;
      mul_flush  <= flush_next;
      if (accept) begin
        mul_mulw         <= op_word;
        mul_signed       <= signed_sel;
        mul_multiplicand <= src1_sel;
        mul_multiplier   <= src2_sel;
        sel_hi           <= !op_word && !op_func[2] && (op_func[1:0] != 2'b00);
      end
      if (capture)     res_data    <= result_sel;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_issuer.sv
// tb_mul_issuer: directed vectors for mul_issuer against a behavioural stub multiplier
// whose latency, silence and flush handling can be steered per test.
module tb_mul_issuer;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_func;
  logic        op_word;
  logic [63:0] op_src1;
  logic [63:0] op_src2;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        timeout_err;
  logic        mul_in_valid;
  logic        mul_flush;
  logic        mul_mulw;
  logic [1:0]  mul_signed;
  logic [63:0] mul_multiplicand;
  logic [63:0] mul_multiplier;
  logic        mul_out_ready;
  logic        mul_out_valid;
  logic [63:0] mul_result_hi;
  logic [63:0] mul_result_lo;

  int n_compared = 0;
  int n_mismatch = 0;

  int   stub_lat;
  bit   stub_mute;
  bit   stub_ignore_flush;
  logic stub_busy;
  int   stub_cnt;
  logic [127:0] a_ext;
  logic [127:0] b_ext;
  logic [127:0] prod;

  mul_issuer #(.XLEN(64), .TIMEOUT(63)) dut (
    .clock            (clock),
    .reset            (reset),
    .flush            (flush),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .op_func          (op_func),
    .op_word          (op_word),
    .op_src1          (op_src1),
    .op_src2          (op_src2),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .timeout_err      (timeout_err),
    .mul_in_valid     (mul_in_valid),
    .mul_flush        (mul_flush),
    .mul_mulw         (mul_mulw),
    .mul_signed       (mul_signed),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_out_ready    (mul_out_ready),
    .mul_out_valid    (mul_out_valid),
    .mul_result_hi    (mul_result_hi),
    .mul_result_lo    (mul_result_lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stub multiplier: full 128-bit product of the operands as the signedness field says.
  always_comb begin
    a_ext = mul_signed[1] ? {{64{mul_multiplicand[63]}}, mul_multiplicand} : {64'd0, mul_multiplicand};
    b_ext = mul_signed[0] ? {{64{mul_multiplier[63]}}, mul_multiplier} : {64'd0, mul_multiplier};
    prod  = a_ext * b_ext;
  end

  assign mul_out_ready = ~stub_busy;

  always @(posedge clock) begin
    if (reset) begin
      stub_busy     <= 1'b0;
      stub_cnt      <= 0;
      mul_out_valid <= 1'b0;
      mul_result_hi <= 64'd0;
      mul_result_lo <= 64'd0;
    end else begin
      mul_out_valid <= 1'b0;
      if (mul_flush && !stub_ignore_flush) begin
        stub_busy <= 1'b0;
      end else if (stub_busy) begin
        if (!stub_mute) begin
          if (stub_cnt == 0) begin
            stub_busy     <= 1'b0;
            mul_out_valid <= 1'b1;
          end else begin
            stub_cnt <= stub_cnt - 1;
          end
        end
      end else if (mul_in_valid) begin
        stub_busy     <= 1'b1;
        stub_cnt      <= stub_lat;
        mul_result_hi <= prod[127:64];
        mul_result_lo <= prod[63:0];
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Present one op and hold it until accepted; returns in the cycle after the accept edge.
  task automatic applyStimulus(input logic [2:0] f, input logic w, input logic [63:0] a,
                               input logic [63:0] b);
    int n;
    op_valid = 1'b1;
    op_func  = f;
    op_word  = w;
    op_src1  = a;
    op_src2  = b;
    n = 0;
    while (!op_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput("op_accept", 64'(op_ready), 64'd1);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic waitResult(output bit found, output int n, output int inv);
    inv = mul_in_valid ? 1 : 0;
    n   = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
      if (mul_in_valid) inv++;
    end
    found = res_valid;
  endtask

  task automatic runOp(input string tag, input logic [2:0] f, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] exp_sig, input logic [63:0] exp_res);
    bit found;
    int n;
    int inv;
    applyStimulus(f, w, a, b);
    checkOutput({tag, "_in_valid"}, 64'(mul_in_valid), 64'd1);
    checkOutput({tag, "_signed"}, 64'(mul_signed), 64'(exp_sig));
    checkOutput({tag, "_mulw"}, 64'(mul_mulw), 64'(w));
    waitResult(found, n, inv);
    checkOutput({tag, "_res_valid"}, 64'(found), 64'd1);
    checkOutput({tag, "_latency"}, 64'(n), 64'd5);
    checkOutput({tag, "_res_data"}, res_data, exp_res);
    checkOutput({tag, "_in_valid_cycles"}, 64'(inv), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput({tag, "_released"}, 64'(res_valid), 64'd0);
    checkOutput({tag, "_op_ready_after"}, 64'(op_ready), 64'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_op_ready"}, 64'(op_ready), 64'd1);
    checkOutput({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    checkOutput({tag, "_res_data"}, res_data, 64'd0);
    checkOutput({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    checkOutput({tag, "_in_valid"}, 64'(mul_in_valid), 64'd0);
    checkOutput({tag, "_mul_flush"}, 64'(mul_flush), 64'd0);
    checkOutput({tag, "_mulw"}, 64'(mul_mulw), 64'd0);
    checkOutput({tag, "_signed"}, 64'(mul_signed), 64'd0);
    checkOutput({tag, "_mcand"}, mul_multiplicand, 64'd0);
    checkOutput({tag, "_mplier"}, mul_multiplier, 64'd0);
  endtask

  initial begin
    bit found;
    int n;
    int inv;
    int bad;
    int flush_seen;
    int valid_seen;
    int late_seen;
    logic [63:0] held;

    reset = 1'b1;
    flush = 1'b0;
    op_valid = 1'b0;
    op_func = 3'b000;
    op_word = 1'b0;
    op_src1 = 64'd0;
    op_src2 = 64'd0;
    res_ready = 1'b0;
    stub_lat = 2;
    stub_mute = 1'b0;
    stub_ignore_flush = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    checkResetState("reset");

    $display("[TB] basic MUL and high halves");
    runOp("mul_3xm5", 3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 2'b11, 64'hFFFF_FFFF_FFFF_FFF1);
    checkOutput("mul_3xm5_mcand", mul_multiplicand, 64'd3);
    runOp("mulhu_ones", 3'b011, 1'b0, '1, '1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFE);
    runOp("mulh_ones", 3'b001, 1'b0, '1, '1, 2'b11, 64'h0);
    runOp("mulhsu_ones", 3'b010, 1'b0, '1, '1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("func1xx_as_mul", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 2'b11,
          64'hFFFF_FFFF_FFFF_FFFA);

    $display("[TB] MULW");
    runOp("mulw_neg", 3'b011, 1'b1, 64'h4000_0000, 64'd2, 2'b11, 64'hFFFF_FFFF_8000_0000);
    runOp("mulw_trunc", 3'b000, 1'b1, 64'h1_0000_0003, 64'd5, 2'b11, 64'hF);
    checkOutput("mulw_trunc_mcand", mul_multiplicand, 64'd3);

    $display("[TB] result held while res_ready low");
    applyStimulus(3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd4);
    waitResult(found, n, inv);
    checkOutput("hold_res_valid", 64'(found), 64'd1);
    checkOutput("hold_res_data", res_data, 64'd2);
    held = res_data;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!res_valid || res_data !== held || op_ready) bad++;
    end
    checkOutput("hold_stable_cycles", 64'(bad), 64'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("hold_released", 64'(res_valid), 64'd0);

    $display("[TB] flush during WAIT");
    stub_lat = 12;
    stub_ignore_flush = 1'b1;
    applyStimulus(3'b000, 1'b0, 64'd7, 64'd6);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_mul_flush", 64'(mul_flush), 64'd1);
    flush_seen = 0;
    valid_seen = 0;
    late_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mul_flush) flush_seen++;
      if (res_valid) valid_seen++;
      if (mul_out_valid) late_seen++;
    end
    checkOutput("flush_pulse_extra", 64'(flush_seen), 64'd0);
    checkOutput("flush_late_valid_seen", 64'(late_seen), 64'd1);
    checkOutput("flush_no_result", 64'(valid_seen), 64'd0);
    checkOutput("flush_back_idle", 64'(op_ready), 64'd1);
    stub_lat = 2;
    stub_ignore_flush = 1'b0;
    runOp("after_flush_7x6", 3'b000, 1'b0, 64'd7, 64'd6, 2'b11, 64'd42);

    $display("[TB] watchdog timeout");
    stub_mute = 1'b1;
    applyStimulus(3'b011, 1'b0, 64'd5, 64'd7);
    repeat (63) tick();
    checkOutput("timeout_not_yet", 64'(timeout_err), 64'd0);
    tick();
    checkOutput("timeout_set", 64'(timeout_err), 64'd1);
    checkOutput("timeout_mul_flush", 64'(mul_flush), 64'd1);
    flush_seen = 1;
    n = 0;
    while (!op_ready && n < 10) begin
      tick();
      n++;
      if (mul_flush) flush_seen++;
    end
    checkOutput("timeout_back_idle", 64'(op_ready), 64'd1);
    checkOutput("timeout_flush_cycles", 64'(flush_seen), 64'd1);
    checkOutput("timeout_res_valid", 64'(res_valid), 64'd0);
    tick();
    checkOutput("timeout_sticky", 64'(timeout_err), 64'd1);

    $display("[TB] reset during WAIT");
    applyStimulus(3'b000, 1'b1, 64'd9, 64'd9);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkResetState("midreset");
    stub_mute = 1'b0;
    runOp("after_reset_7x6", 3'b000, 1'b0, 64'd7, 64'd6, 2'b11, 64'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
